// File: rtl/tx_iq_acc_pack.sv
// tx_iq_acc_pack
// Packs pairs of 32-bit I/Q samples into 64-bit words and writes them into
// the tx_intf TX FIFO, following the same word count / endless settings as the
// downstream stream master so both stages agree on the packet length.
// Optional build macro: TX_IQ_PACK_SWAP_EN puts the first sample of each pair
// in the upper half of the word (and the flushed sample in the upper half).

module tx_iq_acc_pack #(
   parameter int IQ_WIDTH               = 32,
   parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
   parameter int FIFO_HIGH_WATERMARK    = 500
) (
   input  logic                              M_AXIS_ACLK,
   input  logic                              M_AXIS_ARESETN,
   input  logic                              start_1trans,
   input  logic                              endless_mode,
   input  logic                              stop_req,
   input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] M_AXIS_NUM_DMA_SYMBOL,
   input  logic [IQ_WIDTH-1:0]               iq_in,
   input  logic                              iq_valid,
   output logic                              iq_ready,
   output logic [2*IQ_WIDTH-1:0]             DATA_TO_ACC,
   output logic                              ACC_DATA_READY,
   input  logic                              FULLN_TO_ACC,
   input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count,
   output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] word_count,
   output logic                              pack_busy,
   output logic                              pack_done
);

   localparam int W = MAX_BIT_NUM_DMA_SYMBOL;
   localparam logic [W-1:0] WATERMARK = W'(FIFO_HIGH_WATERMARK);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PACK  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state;
   state_t next_state;

   logic                  start_ff;
   logic                  start_pulse;
   logic [IQ_WIDTH-1:0]   hold_reg;
   logic                  half;
   logic                  last_word_issued;
   logic                  flush_sent;
   logic                  accept;
   logic                  last_match;
   logic [2*IQ_WIDTH-1:0] packed_word;
   logic [2*IQ_WIDTH-1:0] flush_word;

   assign start_pulse = start_1trans & ~start_ff;
   assign accept      = iq_valid & iq_ready;
   assign last_match  = (word_count == M_AXIS_NUM_DMA_SYMBOL);

`ifdef TX_IQ_PACK_SWAP_EN
   assign packed_word = {hold_reg, iq_in};
   assign flush_word  = {hold_reg, {IQ_WIDTH{1'b0}}};
`else
   assign packed_word = {iq_in, hold_reg};
   assign flush_word  = {{IQ_WIDTH{1'b0}}, hold_reg};
`endif

   // State register; reset drops any transfer in progress immediately.
   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: a bounded transfer ends on the strobe of word N, an
   // endless one on stop_req, flushing a lone held sample first.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start_pulse) begin
               next_state = PACK;
            end
         end
         PACK: begin
            if (endless_mode) begin
               if (stop_req) begin
                  next_state = half ? FLUSH : DONE;
               end
            end else if (ACC_DATA_READY && last_match) begin
               next_state = DONE;
            end
         end
         FLUSH: begin
            if (flush_sent) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Outputs decoded from state; FIFO full and watermark gate sample intake.
   always_comb begin
      iq_ready  = (state == PACK) && FULLN_TO_ACC && (data_count < WATERMARK)
                  && !last_word_issued && !(endless_mode && stop_req);
      pack_busy = (state != IDLE);
      pack_done = (state == DONE);
   end

   // Datapath: start edge capture, sample pairing, FIFO write strobe, word
   // counting and the flush write of an unpaired sample.
   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         start_ff         <= 1'b0;
         hold_reg         <= '0;
         half             <= 1'b0;
         last_word_issued <= 1'b0;
         flush_sent       <= 1'b0;
         DATA_TO_ACC      <= '0;
         ACC_DATA_READY   <= 1'b0;
         word_count       <= '0;
      end else begin
         start_ff       <= start_1trans;
         ACC_DATA_READY <= 1'b0;
         if (ACC_DATA_READY) begin
            word_count <= word_count + W'(1);
         end
         case (state)
            IDLE: begin
               last_word_issued <= 1'b0;
               flush_sent       <= 1'b0;
               if (start_pulse) begin
                  word_count <= '0;
                  half       <= 1'b0;
               end
            end
            PACK: begin
               if (accept) begin
                  if (!half) begin
                     hold_reg <= iq_in;
                     half     <= 1'b1;
                  end else begin
                     DATA_TO_ACC    <= packed_word;
                     ACC_DATA_READY <= 1'b1;
                     half           <= 1'b0;
                     if (!endless_mode && last_match) begin
                        last_word_issued <= 1'b1;
                     end
                  end
               end
            end
            FLUSH: begin
               if (FULLN_TO_ACC && !flush_sent) begin
                  DATA_TO_ACC    <= flush_word;
                  ACC_DATA_READY <= 1'b1;
                  flush_sent     <= 1'b1;
                  half           <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_iq_acc_pack.sv
// tb_tx_iq_acc_pack
// Self-checking bench for tx_iq_acc_pack. Expected FIFO words are queued as
// sample pairs are handed over and compared whenever the write strobe fires.
// Honours TX_IQ_PACK_SWAP_EN the same way the design does.

`timescale 1ns/1ps

module tb_tx_iq_acc_pack;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_1trans;
   logic        endless_mode;
   logic        stop_req;
   logic [13:0] num_sym;
   logic [31:0] iq_in;
   logic        iq_valid;
   logic        iq_ready;
   logic [63:0] data_to_acc;
   logic        acc_data_ready;
   logic        fulln;
   logic [13:0] data_count;
   logic [13:0] word_count;
   logic        pack_busy;
   logic        pack_done;

   logic [63:0] exp_q[$];
   logic [63:0] exp_w;
   int          checks = 0;
   int          errors = 0;
   logic        tb_half;
   logic [31:0] tb_hold;

   tx_iq_acc_pack dut (
      .M_AXIS_ACLK           (clk),
      .M_AXIS_ARESETN        (rst_n),
      .start_1trans          (start_1trans),
      .endless_mode          (endless_mode),
      .stop_req              (stop_req),
      .M_AXIS_NUM_DMA_SYMBOL (num_sym),
      .iq_in                 (iq_in),
      .iq_valid              (iq_valid),
      .iq_ready              (iq_ready),
      .DATA_TO_ACC           (data_to_acc),
      .ACC_DATA_READY        (acc_data_ready),
      .FULLN_TO_ACC          (fulln),
      .data_count            (data_count),
      .word_count            (word_count),
      .pack_busy             (pack_busy),
      .pack_done             (pack_done)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Word layout the FIFO should receive for a pair (first, second)
   function automatic logic [63:0] make_word(input logic [31:0] first, input logic [31:0] second);
`ifdef TX_IQ_PACK_SWAP_EN
      return {first, second};
`else
      return {second, first};
`endif
   endfunction

   // Word layout for a lone sample flushed at the end of an endless transfer
   function automatic logic [63:0] make_flush(input logic [31:0] held);
`ifdef TX_IQ_PACK_SWAP_EN
      return {held, 32'h0};
`else
      return {32'h0, held};
`endif
   endfunction

   // Scoreboard: every FIFO write must match the oldest queued word
   always @(negedge clk) begin
      if (rst_n && acc_data_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_write: got %h, required no write", data_to_acc);
         end else begin
            exp_w = exp_q.pop_front();
            if (data_to_acc !== exp_w) begin
               errors++;
               $display("[TB] FAIL write_data: got %h, required %h", data_to_acc, exp_w);
            end
         end
      end
   end

   // Hard stop in case something wedges outside the bounded waits
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no end of run, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic do_reset();
      rst_n        = 1'b0;
      start_1trans = 1'b0;
      endless_mode = 1'b0;
      stop_req     = 1'b0;
      num_sym      = '0;
      iq_in        = '0;
      iq_valid     = 1'b0;
      fulln        = 1'b1;
      data_count   = '0;
      tb_half      = 1'b0;
      tb_hold      = '0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Raise start for one cycle; returns at posedge+1 with the DUT in PACK
   task automatic start_transfer(input logic endless, input logic [13:0] n);
      endless_mode = endless;
      num_sym      = n;
      tb_half      = 1'b0;
      start_1trans = 1'b1;
      @(posedge clk);
      #1;
      start_1trans = 1'b0;
   endtask

   // Offer one sample until accepted (bounded); updates the expected words
   task automatic send_sample(input logic [31:0] d, output bit ok);
      iq_in    = d;
      iq_valid = 1'b1;
      ok       = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (iq_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      if (ok) begin
         if (tb_half) begin
            exp_q.push_back(make_word(tb_hold, d));
            tb_half = 1'b0;
         end else begin
            tb_hold = d;
            tb_half = 1'b1;
         end
      end
   endtask

   // Wait (bounded) for pack_done; report the preceding strobe and extra pulses
   task automatic wait_done(output bit seen, output bit strobe_before, output int extra);
      logic prev;
      prev          = 1'b0;
      seen          = 1'b0;
      strobe_before = 1'b0;
      extra         = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (pack_done) begin
            seen          = 1'b1;
            strobe_before = prev;
            break;
         end
         prev = acc_data_ready;
      end
      if (seen) begin
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (pack_done) extra++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if (iq_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_iq_ready: got %b, required 0", iq_ready);
      end
      checks++;
      if (data_to_acc !== 64'h0) begin
         errors++; $display("[TB] FAIL reset_data: got %h, required 0", data_to_acc);
      end
      checks++;
      if (acc_data_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_strobe: got %b, required 0", acc_data_ready);
      end
      checks++;
      if (word_count !== 14'd0) begin
         errors++; $display("[TB] FAIL reset_word_count: got %0d, required 0", word_count);
      end
      checks++;
      if (pack_busy !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_busy: got %b, required 0", pack_busy);
      end
      checks++;
      if (pack_done !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_done: got %b, required 0", pack_done);
      end
      do_reset();
   endtask

   task automatic test_non_endless();
      bit ok, seen, sb;
      int extra, timeouts;
      logic [31:0] s;
      endless_mode = 1'b0;
      num_sym      = 14'd3;
      tb_half      = 1'b0;
      start_1trans = 1'b1;
      @(negedge clk);
      checks++;
      if (iq_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL ready_before_start: got %b, required 0", iq_ready);
      end
      @(posedge clk);
      #1;
      start_1trans = 1'b0;
      @(negedge clk);
      checks++;
      if (iq_ready !== 1'b1 || pack_busy !== 1'b1) begin
         errors++; $display("[TB] FAIL start_latency: got ready=%b busy=%b, required 1 1", iq_ready, pack_busy);
      end
      @(posedge clk);
      #1;
      timeouts = 0;
      for (int k = 1; k <= 8; k++) begin
         s = 32'(k) * 32'h00010001;
         send_sample(s, ok);
         if (!ok) timeouts++;
      end
      iq_valid = 1'b0;
      checks++;
      if (iq_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL ready_after_last: got %b, required 0", iq_ready);
      end
      checks++;
      if (timeouts != 0) begin
         errors++; $display("[TB] FAIL ne_sample_timeout: got %0d timeouts, required 0", timeouts);
      end
      wait_done(seen, sb, extra);
      checks++;
      if (!seen || !sb || extra != 0) begin
         errors++; $display("[TB] FAIL ne_done_pulse: got seen=%b after_strobe=%b extra=%0d, required 1 1 0", seen, sb, extra);
      end
      checks++;
      if (word_count !== 14'd4) begin
         errors++; $display("[TB] FAIL ne_word_count: got %0d, required 4", word_count);
      end
      checks++;
      if (pack_busy !== 1'b0 || exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL ne_finish: got busy=%b pending=%0d, required 0 0", pack_busy, exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      bit ok, seen, sb;
      int extra, timeouts, bad;
      logic [31:0] s;
      start_transfer(1'b0, 14'd3);
      timeouts = 0;
      for (int k = 1; k <= 2; k++) begin
         send_sample(32'h0B000000 + 32'(k), ok);
         if (!ok) timeouts++;
      end
      iq_valid = 1'b0;
      @(posedge clk);
      #1;
      fulln    = 1'b0;
      iq_in    = 32'h0B000003;
      iq_valid = 1'b1;
      bad      = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (iq_ready !== 1'b0 || acc_data_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("[TB] FAIL full_stall: got %0d active cycles, required 0", bad);
      end
      @(posedge clk);
      #1;
      fulln = 1'b1;
      for (int k = 3; k <= 8; k++) begin
         s = 32'h0B000000 + 32'(k);
         send_sample(s, ok);
         if (!ok) timeouts++;
      end
      iq_valid = 1'b0;
      checks++;
      if (timeouts != 0) begin
         errors++; $display("[TB] FAIL bp_sample_timeout: got %0d timeouts, required 0", timeouts);
      end
      wait_done(seen, sb, extra);
      checks++;
      if (!seen || word_count !== 14'd4 || exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL bp_finish: got seen=%b count=%0d pending=%0d, required 1 4 0", seen, word_count, exp_q.size());
      end
   endtask

   task automatic test_n0_watermark();
      bit ok, seen, sb;
      int extra, timeouts;
      data_count = 14'd500;
      start_transfer(1'b0, 14'd0);
      checks++;
      if (iq_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL watermark_500: got %b, required 0", iq_ready);
      end
      data_count = 14'd499;
      #1;
      checks++;
      if (iq_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL watermark_499: got %b, required 1", iq_ready);
      end
      timeouts = 0;
      send_sample(32'h00010001, ok);
      if (!ok) timeouts++;
      send_sample(32'h00020002, ok);
      if (!ok) timeouts++;
      iq_valid = 1'b0;
      checks++;
      if (timeouts != 0 || iq_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL n0_intake: got timeouts=%0d ready=%b, required 0 0", timeouts, iq_ready);
      end
      wait_done(seen, sb, extra);
      checks++;
      if (!seen || !sb || word_count !== 14'd1 || exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL n0_finish: got seen=%b after_strobe=%b count=%0d pending=%0d, required 1 1 1 0", seen, sb, word_count, exp_q.size());
      end
      data_count = '0;
   endtask

   task automatic test_endless_flush();
      bit ok, seen, sb;
      int extra, timeouts;
      start_transfer(1'b1, 14'd0);
      timeouts = 0;
      for (int k = 1; k <= 7; k++) begin
         send_sample(32'(k) * 32'h00010001, ok);
         if (!ok) timeouts++;
      end
      iq_in    = 32'h00080008;
      iq_valid = 1'b1;
      stop_req = 1'b1;
      #1;
      checks++;
      if (iq_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL stop_blocks_sample: got %b, required 0", iq_ready);
      end
      exp_q.push_back(make_flush(tb_hold));
      tb_half = 1'b0;
      checks++;
      if (timeouts != 0) begin
         errors++; $display("[TB] FAIL en_sample_timeout: got %0d timeouts, required 0", timeouts);
      end
      wait_done(seen, sb, extra);
      checks++;
      if (!seen || !sb || extra != 0) begin
         errors++; $display("[TB] FAIL en_done_pulse: got seen=%b after_strobe=%b extra=%0d, required 1 1 0", seen, sb, extra);
      end
      checks++;
      if (word_count !== 14'd4 || exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL en_finish: got count=%0d pending=%0d, required 4 0", word_count, exp_q.size());
      end
      stop_req     = 1'b0;
      iq_valid     = 1'b0;
      endless_mode = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok, seen, sb;
      int extra, timeouts;
      start_transfer(1'b0, 14'd3);
      timeouts = 0;
      for (int k = 1; k <= 3; k++) begin
         send_sample(32'h0C000000 + 32'(k), ok);
         if (!ok) timeouts++;
      end
      iq_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      checks++;
      if (iq_ready !== 1'b0 || acc_data_ready !== 1'b0 || pack_busy !== 1'b0 || pack_done !== 1'b0) begin
         errors++; $display("[TB] FAIL mid_reset_flags: got ready=%b strobe=%b busy=%b done=%b, required 0 0 0 0", iq_ready, acc_data_ready, pack_busy, pack_done);
      end
      checks++;
      if (data_to_acc !== 64'h0 || word_count !== 14'd0) begin
         errors++; $display("[TB] FAIL mid_reset_regs: got data=%h count=%0d, required 0 0", data_to_acc, word_count);
      end
      exp_q.delete();
      tb_half = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      start_transfer(1'b0, 14'd0);
      checks++;
      if (word_count !== 14'd0 || pack_busy !== 1'b1) begin
         errors++; $display("[TB] FAIL restart: got count=%0d busy=%b, required 0 1", word_count, pack_busy);
      end
      send_sample(32'hA1A1A1A1, ok);
      if (!ok) timeouts++;
      send_sample(32'hB2B2B2B2, ok);
      if (!ok) timeouts++;
      iq_valid = 1'b0;
      wait_done(seen, sb, extra);
      checks++;
      if (timeouts != 0 || !seen || word_count !== 14'd1 || exp_q.size() != 0) begin
         errors++; $display("[TB] FAIL restart_finish: got timeouts=%0d seen=%b count=%0d pending=%0d, required 0 1 1 0", timeouts, seen, word_count, exp_q.size());
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      do_reset();
      test_reset();
      test_non_endless();
      test_backpressure();
      test_n0_watermark();
      test_endless_flush();
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
